// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC accumulate stage.
package mac_pkg;

  localparam int PROD_W    = 36;
  localparam int ACC_W_DEF = 48;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // One-bit extension of a product; the caller sign-extends the result to the accumulator width.
  function automatic logic [PROD_W:0] ext_prod(input logic [PROD_W-1:0] p, input logic sgn);
    return {sgn & p[PROD_W-1], p};
  endfunction

endpackage

// File: rtl/mac_acc_add.sv
// Combinational accumulator adder with signed/unsigned overflow detection.
module mac_acc_add #(
  parameter int ACC_W = 48
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic             mode_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = full[ACC_W-1:0];

  // Signed: like-signed addends producing an opposite-signed sum. Unsigned: carry out.
  assign ovf_o = mode_i ? ((a_i[ACC_W-1] == b_i[ACC_W-1]) && (sum_o[ACC_W-1] != a_i[ACC_W-1]))
                        : full[ACC_W];

endmodule

// File: rtl/mac_acc36.sv
// Accumulates a programmed number of 36-bit multiplier products into a wide sum.
module mac_acc36
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_acc_ns,
  input  logic              i_prod_vld,
  input  logic [PROD_W-1:0] i_prod,
  output logic              o_busy,
  output logic              o_drop,
  output logic              o_acc_vld,
  input  logic              i_acc_rdy,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;

  logic signed [PROD_W:0] ext_short;
  logic [ACC_W-1:0]       ext_op;
  logic [ACC_W-1:0]       sum;
  logic                   add_ovf;
  logic                   start_ok;

  assign ext_short = ext_prod(i_prod, mode_q);
  assign ext_op    = ACC_W'(ext_short);

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .a_i    (acc_q),
    .b_i    (ext_op),
    .mode_i (mode_q),
    .sum_o  (sum),
    .ovf_o  (add_ovf)
  );

  // A new transaction is taken from IDLE, or from HOLD in the same cycle the result is consumed.
  assign start_ok = i_start && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_acc_rdy));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    drop_d  = i_prod_vld && (state_q != ST_ACCUM);

    case (state_q)
      ST_ACCUM: begin
        if (i_prod_vld) begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_acc_rdy) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = i_len;
      mode_d  = i_acc_ns;
      state_d = (i_len != '0) ? ST_ACCUM : ST_HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_acc_vld = (state_q == ST_HOLD);
  assign o_acc     = acc_q;
  assign o_ovf     = ovf_q;
  assign o_drop    = drop_q;

endmodule
